// File: rtl/sseg_scan_bcd_pkg.sv
// sseg_pkg: shared types, segment constants and glyph table
// for the sseg_scan_bcd seven-segment scanner (active-low segments).
package sseg_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_DASH  = 7'b0111111;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic seg_t glyph(bcd_t d);
    seg_t s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sseg_scan_bcd_if.sv
// sseg_scan_bcd_if: datapath-side inputs and display-pin outputs
// of the scanner; master = datapath/board, slave = scanner.
interface sseg_scan_bcd_if #(
  parameter int NUM_DIGITS = 4
);
  import sseg_pkg::*;

  localparam int IW = $clog2(NUM_DIGITS);

  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   an;
  seg_t                    sseg;
  logic                    dp;
  logic [IW-1:0]           digit_idx;

  modport master (
    output en, digits, dp_in,
    input  an, sseg, dp, digit_idx
  );

  modport slave (
    input  en, digits, dp_in,
    output an, sseg, dp, digit_idx
  );

endinterface

// File: rtl/sseg_scan_bcd_decoder.sv
// sseg_decoder: BCD nibble to active-low segments;
// non-BCD codes 10..15 render as a dash.
module sseg_decoder
  import sseg_pkg::*;
(
  input  bcd_t num,
  output seg_t sseg
);

  assign sseg = (num > 4'd9) ? SEG_DASH : glyph(num);

endmodule

// File: rtl/sseg_scan_bcd.sv
// sseg_scan_bcd: N-digit multiplexed common-anode BCD display driver.
// Optional leading-zero blanking when SSEG_LZB_EN is defined.
module sseg_scan_bcd
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  sseg_scan_bcd_if.slave bus
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int W  = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_N = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [W-1:0]          dig_q, dig_d;
  logic [NUM_DIGITS-1:0] dps_q, dps_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  seg_t                  sseg_q, sseg_d;
  logic                  dp_q, dp_d;
  logic [IW-1:0]         didx_q, didx_d;

  logic tick;
  logic lzb;
  bcd_t cur;
  seg_t cur_seg;

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    cur = dig_q[{idx_q, 2'b00} +: 4];
  end

  sseg_decoder u_dec (
    .num  (cur),
    .sseg (cur_seg)
  );

`ifdef SSEG_LZB_EN
  // zero_hi[i]: digit i and every digit above it are zero
  logic [NUM_DIGITS-1:0] zero_hi;

  always_comb begin
    zero_hi = '0;
    zero_hi[NUM_DIGITS-1] = (dig_q[W-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_hi[i] = zero_hi[i+1] &&
                   (dig_q[4*i +: 4] == 4'd0);
    end
  end

  assign lzb = (idx_q != '0) && zero_hi[idx_q];
`else
  assign lzb = 1'b0;
`endif

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    dig_d  = dig_q;
    dps_d  = dps_q;
    an_d   = ~(NUM_DIGITS'(1) << idx_q);
    sseg_d = lzb ? SEG_BLANK : cur_seg;
    dp_d   = ~dps_q[idx_q];
    didx_d = idx_q;

    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end

    // Frame boundary: take a fresh snapshot of the datapath
    if (tick && idx_q == IDX_MAX) begin
      dig_d = bus.digits;
      dps_d = bus.dp_in;
    end

    if (cnt_q < BLANK_N) begin
      an_d = '1;
    end

    if (!bus.en) begin
      cnt_d  = '0;
      idx_d  = '0;
      dig_d  = bus.digits;
      dps_d  = bus.dp_in;
      an_d   = '1;
      sseg_d = SEG_BLANK;
      dp_d   = 1'b1;
      didx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      dig_q  <= '0;
      dps_q  <= '0;
      an_q   <= '1;
      sseg_q <= SEG_BLANK;
      dp_q   <= 1'b1;
      didx_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      dig_q  <= dig_d;
      dps_q  <= dps_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
      dp_q   <= dp_d;
      didx_q <= didx_d;
    end
  end

  assign bus.an        = an_q;
  assign bus.sseg      = sseg_q;
  assign bus.dp        = dp_q;
  assign bus.digit_idx = didx_q;

endmodule

// File: tb/tb_sseg_scan_bcd.sv
// tb_sseg_scan_bcd: vector table, hand sequences and a random run
// against a time-based reference model of the scanner.
module tb_sseg_scan_bcd;
  import sseg_pkg::*;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BC = 2;
`ifdef SSEG_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sseg_scan_bcd_if #(.NUM_DIGITS(N)) bus ();

  sseg_scan_bcd #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Glyph from the list of lit segments; non-BCD lights g only.
  function automatic logic [6:0] ref_glyph(int v);
    string s;
    logic [6:0] r;
    case (v)
      0: s = "abcdef";
      1: s = "bc";
      2: s = "abdeg";
      3: s = "abcdg";
      4: s = "bcfg";
      5: s = "acdfg";
      6: s = "acdefg";
      7: s = "abc";
      8: s = "abcdefg";
      9: s = "abcdfg";
      default: s = "g";
    endcase
    r = '1;
    for (int k = 0; k < s.len(); k++)
      r[int'(s.getc(k)) - 97] = 1'b0;
    return r;
  endfunction

  // Reference: t = enabled cycles since scan start.
  int          t;
  int          slot, ph;
  logic [15:0] m_dig;
  logic [3:0]  m_dp;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [1:0]  e_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !bus.en) begin
      t = 0;
      m_dig = rst_n ? bus.digits : 16'h0;
      m_dp  = rst_n ? bus.dp_in : 4'h0;
      e_an = 4'hF; e_seg = 7'h7F;
      e_dp = 1'b1; e_idx = 2'd0;
    end else begin
      slot  = (t / RD) % N;
      ph    = t % RD;
      e_idx = 2'(slot);
      e_an  = (ph < BC) ? 4'hF : ~(4'b1 << slot);
      e_seg = ref_glyph(int'((m_dig >> (4*slot)) & 16'hF));
      if (LZB && slot > 0 && (m_dig >> (4*slot)) == 0)
        e_seg = 7'h7F;
      e_dp = ~m_dp[slot];
      if (t % (N*RD) == N*RD - 1) begin
        m_dig = bus.digits;
        m_dp  = bus.dp_in;
      end
      t++;
    end
  end

  bit chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_an", 32'(bus.an), 32'(e_an));
      check("model_sseg", 32'(bus.sseg), 32'(e_seg));
      check("model_dp", 32'(bus.dp), 32'(e_dp));
      check("model_idx", 32'(bus.digit_idx), 32'(e_idx));
      check("an_onehot",
            32'($countones(~bus.an) <= 1), 32'd1);
    end
  end

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    int          idx;
    logic [6:0]  seg;
    logic        dpo;
  } vec_t;

  vec_t vt[$];
  int   tt;
  logic [3:0] f_an [4];
  logic [6:0] f_seg [4];
  int   last_wrap, n_wrap;
  logic [1:0] prev_idx;

  task automatic step(int n);
    repeat (n) @(negedge clk);
    tt += n;
  endtask

  task automatic slot_chk(string nm, logic [3:0] an,
                          logic [6:0] seg);
    check({nm, "_an"}, 32'(bus.an), 32'(an));
    check({nm, "_sseg"}, 32'(bus.sseg), 32'(seg));
  endtask

  initial begin
    vt.push_back('{16'h1234, 4'b0000, 0, 7'h19, 1'b1});
    vt.push_back('{16'h1234, 4'b0000, 3, 7'h79, 1'b1});
    vt.push_back('{16'h00A0, 4'b0100, 0, 7'h40, 1'b1});
    vt.push_back('{16'h00A0, 4'b0100, 1, 7'h3F, 1'b1});
    vt.push_back('{16'h00A0, 4'b0100, 2,
                   LZB ? 7'h7F : 7'h40, 1'b0});
    vt.push_back('{16'h00A0, 4'b0100, 3,
                   LZB ? 7'h7F : 7'h40, 1'b1});
    vt.push_back('{16'h9F05, 4'b1001, 0, 7'h12, 1'b0});
    vt.push_back('{16'h9F05, 4'b1001, 1, 7'h40, 1'b1});
    vt.push_back('{16'h9F05, 4'b1001, 2, 7'h3F, 1'b1});
    vt.push_back('{16'h9F05, 4'b1001, 3, 7'h10, 1'b0});
    vt.push_back('{16'h0000, 4'b0001, 0, 7'h40, 1'b0});
    vt.push_back('{16'h0000, 4'b0001, 3,
                   LZB ? 7'h7F : 7'h40, 1'b1});

    f_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    f_seg = '{7'h19, 7'h30, 7'h24, 7'h79};

    bus.en = 1'b0;
    bus.digits = 16'h0;
    bus.dp_in = 4'h0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_an", 32'(bus.an), 32'hF);
    check("rst_sseg", 32'(bus.sseg), 32'h7F);
    check("rst_dp", 32'(bus.dp), 32'd1);
    check("rst_idx", 32'(bus.digit_idx), 32'd0);

    // First frame of 1234
    bus.digits = 16'h1234;
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    bus.en = 1'b1;
    tt = -1;
    for (int c = 0; c < 32; c++) begin
      step(1);
      if (c % RD < BC)
        check("frame_gap", 32'(bus.an), 32'hF);
      else
        slot_chk("frame", f_an[c/RD], f_seg[c/RD]);
    end

    // Mid-frame change during slot 1
    step(10);
    bus.digits = 16'h5678;
    step(9);  slot_chk("old2", 4'b1011, 7'h24);
    step(8);  slot_chk("old1", 4'b0111, 7'h79);
    step(8);  slot_chk("new8", 4'b1110, 7'h00);
    step(8);  slot_chk("new7", 4'b1101, 7'h78);
    step(8);  slot_chk("new6", 4'b1011, 7'h02);
    step(8);  slot_chk("new5", 4'b0111, 7'h12);

    // Enable dropped for 3 cycles mid-slot
    bus.en = 1'b0;
    step(1);
    slot_chk("en0", 4'hF, 7'h7F);
    check("en0_idx", 32'(bus.digit_idx), 32'd0);
    step(2);
    bus.en = 1'b1;
    step(1);
    check("reen_gap0", 32'(bus.an), 32'hF);
    check("reen_idx", 32'(bus.digit_idx), 32'd0);
    step(1);
    check("reen_gap1", 32'(bus.an), 32'hF);
    step(1);
    slot_chk("reen_d0", 4'b1110, 7'h00);

    // Vector table: snapshot via en=0, then run to the slot
    foreach (vt[i]) begin
      bus.digits = vt[i].digits;
      bus.dp_in  = vt[i].dp;
      bus.en = 1'b0;
      step(1);
      bus.en = 1'b1;
      step(vt[i].idx * RD + BC + 3);
      slot_chk($sformatf("vec%0d", i),
               ~(4'b1 << vt[i].idx), vt[i].seg);
      check($sformatf("vec%0d_dp", i),
            32'(bus.dp), 32'(vt[i].dpo));
    end

    // Asynchronous reset mid-slot
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", 32'(bus.an), 32'hF);
    check("arst_dp", 32'(bus.dp), 32'd1);
    check("arst_sseg", 32'(bus.sseg), 32'h7F);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check("post_rst_idx", 32'(bus.digit_idx), 32'd0);
    check("post_rst_an", 32'(bus.an), 32'hF);

    // Wrap period over several frames
    n_wrap = 0;
    last_wrap = -1;
    prev_idx = bus.digit_idx;
    for (int c = 0; c < 140; c++) begin
      step(1);
      if (prev_idx == 2'd3 && bus.digit_idx == 2'd0) begin
        if (last_wrap >= 0)
          check("wrap_period", 32'(c - last_wrap), 32'd32);
        last_wrap = c;
        n_wrap++;
      end
      prev_idx = bus.digit_idx;
    end
    check("wrap_count", 32'(n_wrap), 32'd4);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0)
        bus.digits = 16'($urandom);
      if ($urandom_range(15) == 0)
        bus.dp_in = 4'($urandom);
      bus.en = ($urandom_range(49) != 0);
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
